// File: rtl/mainfsm_decoder.sv
// Multicycle ARM control: main FSM, ALU decoder and PC-write logic.
// Drives unconditioned PCs/RegW/MemW/FlagW for condlogic plus datapath selects.
module mainfsm_decoder #(
    parameter logic [3:0] PC_REG       = 4'd15,
    parameter bit         UNKNOWN_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCs,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    state_t state_q, state_d;
    logic   alu_op;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_UNKNOWN:  state_d = UNKNOWN_TRAP ? S_UNKNOWN : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore control outputs, decoded purely from the current state
    always_comb begin
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_op    = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Unsupported commands decode to ADD with no flag update
    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                4'b0100: FlagW = {Funct[0], Funct[0]};
                4'b0010: begin
                    ALUControl = 2'b01;
                    FlagW      = {Funct[0], Funct[0]};
                end
                4'b0000: begin
                    ALUControl = 2'b10;
                    FlagW      = {Funct[0], 1'b0};
                end
                4'b1100: begin
                    ALUControl = 2'b11;
                    FlagW      = {Funct[0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign PCs    = (RegW && (Rd == PC_REG)) || branch;
    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = state_q;

endmodule

// File: tb/tb_mainfsm_decoder.sv
// Directed vector bench for mainfsm_decoder: per-cycle state/output table,
// FETCH-to-FETCH latencies and the UNKNOWN trap variant.
module tb_mainfsm_decoder;

    typedef struct packed {
        logic [3:0] st;
        logic       pcs;
        logic       npc;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       irw;
        logic       adr;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluc;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        exp_t       e;
    } vec_t;

    localparam exp_t E_FETCH = '{st: 4'd0, npc: 1'b1, irw: 1'b1,
        res: 2'b10, srca: 1'b1, srcb: 2'b10, default: '0};
    localparam exp_t E_DECODE = '{st: 4'd1, res: 2'b10, srca: 1'b1,
        srcb: 2'b10, default: '0};
    localparam exp_t E_MEMADR = '{st: 4'd2, srcb: 2'b01, default: '0};
    localparam exp_t E_MEMREAD = '{st: 4'd3, adr: 1'b1, default: '0};
    localparam exp_t E_MEMWB = '{st: 4'd4, res: 2'b01, regw: 1'b1,
        default: '0};
    localparam exp_t E_MEMWRITE = '{st: 4'd5, adr: 1'b1, memw: 1'b1,
        default: '0};
    localparam exp_t E_EXR = '{st: 4'd6, default: '0};
    localparam exp_t E_EXI = '{st: 4'd7, srcb: 2'b01, default: '0};
    localparam exp_t E_ALUWB = '{st: 4'd8, regw: 1'b1, default: '0};
    localparam exp_t E_BRANCH = '{st: 4'd9, srcb: 2'b01, res: 2'b10,
        pcs: 1'b1, default: '0};
    localparam exp_t E_UNK = '{st: 4'd10, default: '0};

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCs, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    logic       t_PCs, t_NextPC, t_RegW, t_MemW, t_IRWrite, t_AdrSrc;
    logic       t_ALUSrcA;
    logic [1:0] t_FlagW, t_ResultSrc, t_ALUSrcB, t_ALUControl;
    logic [1:0] t_ImmSrc, t_RegSrc;
    logic [3:0] t_State;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mainfsm_decoder dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .PCs(PCs), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .FlagW(FlagW), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .State(State)
    );

    mainfsm_decoder #(.UNKNOWN_TRAP(1'b1)) dut_trap (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .PCs(t_PCs), .NextPC(t_NextPC), .RegW(t_RegW), .MemW(t_MemW),
        .FlagW(t_FlagW), .IRWrite(t_IRWrite), .AdrSrc(t_AdrSrc),
        .ResultSrc(t_ResultSrc), .ALUSrcA(t_ALUSrcA),
        .ALUSrcB(t_ALUSrcB), .ALUControl(t_ALUControl),
        .ImmSrc(t_ImmSrc), .RegSrc(t_RegSrc), .State(t_State)
    );

    function automatic exp_t alu(exp_t e, logic [1:0] c, logic [1:0] f);
        exp_t r = e;
        r.aluc  = c;
        r.flagw = f;
        return r;
    endfunction

    function automatic exp_t pc(exp_t e);
        exp_t r = e;
        r.pcs = 1'b1;
        return r;
    endfunction

    task automatic push(input logic r, input logic [1:0] o,
                        input logic [5:0] f, input logic [3:0] d,
                        input exp_t e);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.rd = d; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic latency(input string name, input logic [1:0] o,
                           input logic [5:0] f, input int exp);
        int n = 0;
        Op = o; Funct = f; Rd = 4'd2;
        do begin
            @(posedge clk); #1;
            n++;
        end while (State != 4'd0 && n < 12);
        chk(name, n, exp);
    endtask

    initial begin
        exp_t a;
        reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;

        push(1, 2'b00, 6'b000000, 4'd0, E_FETCH);
        push(1, 2'b00, 6'b000000, 4'd0, E_FETCH);
        // ADDS R1
        push(0, 2'b00, 6'b001001, 4'd1, E_DECODE);
        push(0, 2'b00, 6'b001001, 4'd1, alu(E_EXR, 2'b00, 2'b11));
        push(0, 2'b00, 6'b001001, 4'd1, E_ALUWB);
        push(0, 2'b00, 6'b001001, 4'd1, E_FETCH);
        // LDR R2
        push(0, 2'b01, 6'b011001, 4'd2, E_DECODE);
        push(0, 2'b01, 6'b011001, 4'd2, E_MEMADR);
        push(0, 2'b01, 6'b011001, 4'd2, E_MEMREAD);
        push(0, 2'b01, 6'b011001, 4'd2, E_MEMWB);
        push(0, 2'b01, 6'b011001, 4'd2, E_FETCH);
        // STR
        push(0, 2'b01, 6'b011000, 4'd2, E_DECODE);
        push(0, 2'b01, 6'b011000, 4'd2, E_MEMADR);
        push(0, 2'b01, 6'b011000, 4'd2, E_MEMWRITE);
        push(0, 2'b01, 6'b011000, 4'd2, E_FETCH);
        // B
        push(0, 2'b10, 6'b000000, 4'd0, E_DECODE);
        push(0, 2'b10, 6'b000000, 4'd0, E_BRANCH);
        push(0, 2'b10, 6'b000000, 4'd0, E_FETCH);
        // ORR imm to PC
        push(0, 2'b00, 6'b111000, 4'd15, E_DECODE);
        push(0, 2'b00, 6'b111000, 4'd15, alu(E_EXI, 2'b11, 2'b00));
        push(0, 2'b00, 6'b111000, 4'd15, pc(E_ALUWB));
        push(0, 2'b00, 6'b111000, 4'd15, E_FETCH);
        // SUBS reg, ANDS reg, EOR-S (unsupported), ADD imm no S
        push(0, 2'b00, 6'b000101, 4'd3, E_DECODE);
        push(0, 2'b00, 6'b000101, 4'd3, alu(E_EXR, 2'b01, 2'b11));
        push(0, 2'b00, 6'b000101, 4'd3, E_ALUWB);
        push(0, 2'b00, 6'b000101, 4'd3, E_FETCH);
        push(0, 2'b00, 6'b000001, 4'd4, E_DECODE);
        push(0, 2'b00, 6'b000001, 4'd4, alu(E_EXR, 2'b10, 2'b10));
        push(0, 2'b00, 6'b000001, 4'd4, E_ALUWB);
        push(0, 2'b00, 6'b000001, 4'd4, E_FETCH);
        push(0, 2'b00, 6'b000011, 4'd5, E_DECODE);
        push(0, 2'b00, 6'b000011, 4'd5, alu(E_EXR, 2'b00, 2'b00));
        push(0, 2'b00, 6'b000011, 4'd5, E_ALUWB);
        push(0, 2'b00, 6'b000011, 4'd5, E_FETCH);
        push(0, 2'b00, 6'b101000, 4'd6, E_DECODE);
        push(0, 2'b00, 6'b101000, 4'd6, alu(E_EXI, 2'b00, 2'b00));
        push(0, 2'b00, 6'b101000, 4'd6, E_ALUWB);
        push(0, 2'b00, 6'b101000, 4'd6, E_FETCH);
        // LDR to PC
        push(0, 2'b01, 6'b011001, 4'd15, E_DECODE);
        push(0, 2'b01, 6'b011001, 4'd15, E_MEMADR);
        push(0, 2'b01, 6'b011001, 4'd15, E_MEMREAD);
        push(0, 2'b01, 6'b011001, 4'd15, pc(E_MEMWB));
        push(0, 2'b01, 6'b011001, 4'd15, E_FETCH);
        // Undefined Op
        push(0, 2'b11, 6'b001001, 4'd15, E_DECODE);
        push(0, 2'b11, 6'b001001, 4'd15, E_UNK);
        push(0, 2'b11, 6'b001001, 4'd15, E_FETCH);
        // STR aborted by reset in MEMADR, then rerun
        push(0, 2'b01, 6'b011000, 4'd7, E_DECODE);
        push(0, 2'b01, 6'b011000, 4'd7, E_MEMADR);
        push(1, 2'b01, 6'b011000, 4'd7, E_FETCH);
        push(0, 2'b01, 6'b011000, 4'd7, E_DECODE);
        push(0, 2'b01, 6'b011000, 4'd7, E_MEMADR);
        push(0, 2'b01, 6'b011000, 4'd7, E_MEMWRITE);
        push(0, 2'b01, 6'b011000, 4'd7, E_FETCH);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            Op    = tbl[i].op;
            Funct = tbl[i].funct;
            Rd    = tbl[i].rd;
            @(posedge clk); #1;
            a = '{st: State, pcs: PCs, npc: NextPC, regw: RegW,
                  memw: MemW, flagw: FlagW, irw: IRWrite, adr: AdrSrc,
                  res: ResultSrc, srca: ALUSrcA, srcb: ALUSrcB,
                  aluc: ALUControl};
            chk($sformatf("vec%0d", i), int'(a), int'(tbl[i].e));
            chk($sformatf("vec%0d_imm", i), int'(ImmSrc), int'(tbl[i].op));
            chk($sformatf("vec%0d_regsrc", i), int'(RegSrc),
                int'({tbl[i].op == 2'b01, tbl[i].op == 2'b10}));
        end

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        latency("lat_dp", 2'b00, 6'b001001, 4);
        latency("lat_ldr", 2'b01, 6'b011001, 5);
        latency("lat_str", 2'b01, 6'b011000, 4);
        latency("lat_b", 2'b10, 6'b000000, 3);

        // Trapping variant sticks in UNKNOWN until reset
        Op = 2'b11; Funct = 6'd0; Rd = 4'd0;
        @(posedge clk); #1;
        chk("trap_decode", int'(t_State), 1);
        @(posedge clk); #1;
        chk("trap_unk", int'(t_State), 10);
        chk("notrap_unk", int'(State), 10);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("trap_hold%0d", k), int'(t_State), 10);
            chk($sformatf("trap_irw%0d", k), int'(t_IRWrite), 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("trap_reset", int'(t_State), 0);
        chk("trap_reset_irw", int'(t_IRWrite), 1);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
